// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [ADDR_W_DEFAULT-1:0] PC_STEP_DEFAULT  = 1;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] pc;
    logic [DATA_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer between the fetch PC and decode.
// Entry e0 is always the head; e1 only holds data when count is 2.
// When the buffer empties, e0 keeps its last contents so the head outputs
// hold their previous values instead of toggling.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0;
  fetch_entry_t e1;

  assign head = e0;

  // Entry storage and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) e0 <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, and queues
// {pc, instr} pairs for decode.
//
// Handshake to decode: out_valid means the head entry is meaningful; a
// transfer happens on a rising edge where out_valid & out_ready are both 1.
// While out_valid=1 and out_ready=0 the head (out_pc/out_instr) is held
// stable. out_valid never depends combinationally on out_ready.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic              deq;
  logic              enq;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // The memory address comes straight from the PC register so the memory
  // read path never sees a combinational input-to-output loop.
  assign imem_addr = pc;

  assign out_valid = (count != 2'd0);
  assign deq       = out_valid & out_ready;
  // A redirect suppresses the fetch so the stale-path word is never queued.
  assign enq       = fetch_en & ~redirect_valid & ((count < 2'd2) | deq);

  assign push_entry = '{pc: pc, instr: imem_data};
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;

  // Program counter: redirect first, else advance on each enqueued fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (enq) begin
      pc <= pc + PC_STEP;
    end
  end

  fetch_buffer u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of per-cycle inputs and
// expected outputs, followed by a hand-written asynchronous reset sequence.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        chk_data;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: mem[i] = A000_0000 + i, combinational read.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic en, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] eaddr, input logic cd);
    vec_t v;
    v.rst_n = r; v.en = en; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = eaddr; v.chk_data = cd;
    vecs.push_back(v);
  endtask

  // Drive one row's inputs at the falling edge and compare outputs (which
  // depend only on state) shortly after.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    rst_n          = v.rst_n;
    fetch_en       = v.en;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    out_ready      = v.rdy;
    #1;
    tag = $sformatf("row%0d", idx);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v.exp_valid});
    check({tag, ".imem_addr"}, imem_addr, v.exp_addr);
    if (v.exp_valid) begin
      check({tag, ".out_pc"}, out_pc, v.exp_pc);
      check({tag, ".out_instr"}, out_instr, mem_word(v.exp_pc));
    end else if (v.chk_data) begin
      check({tag, ".out_pc_rst"}, out_pc, 32'h0);
      check({tag, ".out_instr_rst"}, out_instr, 32'h0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    //   rst en rv rpc           rdy  ev  exp_pc        exp_addr      chk
    // Reset, then sequential fetch with decode always ready.
    add(0, 1, 0, 32'h0,        1,   0,  32'h0,        32'h0,        1);
    add(1, 1, 0, 32'h0,        1,   0,  32'h0,        32'h0,        0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h0,        32'h1,        0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h1,        32'h2,        0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h2,        32'h3,        0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h3,        32'h4,        0);
    // Back-pressure from reset: two fetches fill the buffer, pc holds at 2.
    add(0, 1, 0, 32'h0,        0,   0,  32'h0,        32'h0,        1);
    add(1, 1, 0, 32'h0,        0,   0,  32'h0,        32'h0,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h0,        32'h1,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h0,        32'h2,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h0,        32'h2,        0);
    // One ready cycle while full: pop and push together, head 0->1, pc 2->3.
    add(1, 1, 0, 32'h0,        1,   1,  32'h0,        32'h2,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h1,        32'h3,        0);
    // Continuous drain: 1, 2, 3 with no gap or duplicate.
    add(1, 1, 0, 32'h0,        1,   1,  32'h1,        32'h3,        0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h2,        32'h4,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h3,        32'h5,        0);
    // Redirect at pc=5 with entries 3,4 buffered; deq in the same cycle.
    add(1, 1, 1, 32'h40,       1,   1,  32'h3,        32'h5,        0);
    add(1, 1, 0, 32'h0,        1,   0,  32'h0,        32'h40,       0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h40,       32'h41,       0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h41,       32'h42,       0);
    // fetch_en low for 3 cycles: pc frozen at 0x43 while the buffer drains.
    add(1, 0, 0, 32'h0,        1,   1,  32'h41,       32'h43,       0);
    add(1, 0, 0, 32'h0,        1,   1,  32'h42,       32'h43,       0);
    add(1, 0, 0, 32'h0,        1,   0,  32'h0,        32'h43,       0);
    // Redirect to the top of the address space, then wrap to 0.
    add(1, 1, 1, 32'hFFFF_FFFF, 1,  0,  32'h0,        32'h43,       0);
    add(1, 1, 0, 32'h0,        1,   0,  32'h0,        32'hFFFF_FFFF, 0);
    add(1, 1, 0, 32'h0,        1,   1,  32'hFFFF_FFFF, 32'h0,       0);
    add(1, 1, 0, 32'h0,        1,   1,  32'h0,        32'h1,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h1,        32'h2,        0);
    add(1, 1, 0, 32'h0,        0,   1,  32'h1,        32'h3,        0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset between edges while the buffer is full (count=2).
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst.imem_addr", imem_addr, 32'h0);
    check("async_rst.out_pc", out_pc, 32'h0);
    check("async_rst.out_instr", out_instr, 32'h0);

    // Release and confirm fetch restarts at pc 0.
    @(negedge clk);
    rst_n     = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("restart.out_valid0", {31'd0, out_valid}, 32'd0);
    check("restart.imem_addr0", imem_addr, 32'h0);
    @(negedge clk);
    #1;
    check("restart.out_valid1", {31'd0, out_valid}, 32'd1);
    check("restart.out_pc1", out_pc, 32'h0);
    check("restart.out_instr1", out_instr, 32'hA000_0000);
    check("restart.imem_addr1", imem_addr, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of InstructionMemory. Owns the program counter and drives the memory address. Captures the returned instruction word with its PC into a 2-entry buffer, which feeds decode over a valid/ready handshake. Supports fetch enable, and branch/jump redirect with flush.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per fetch (memory is word-addressed)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  ADDR_W  address to InstructionMemory AddrIn; equals current PC
imem_data  input  DATA_W  InstructionMemory DOut; combinational, valid in the same cycle as imem_addr
fetch_en  input  1  enables fetching; 0 = no enqueue, PC held
redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc
redirect_pc  input  ADDR_W  target PC for redirect
out_valid  output  1  buffer head holds a valid instruction
out_instr  output  DATA_W  head instruction
out_pc  output  ADDR_W  PC of head instruction
out_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async assert, release sync to clk): pc=RESET_PC, buffer count=0, out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
- imem_addr = pc, combinational from the register, never from inputs.
- deq = out_valid & out_ready.
- enq = fetch_en & ~redirect_valid & (count<2 | deq).
- On enq, at the rising edge: push {pc, imem_data}; pc <= pc + PC_STEP, wrapping modulo 2^ADDR_W.
- Without enq: pc holds.
- Latency: an instruction addressed in cycle N is at out_* in cycle N+1 if the buffer was empty; otherwise it queues behind older entries in order.
- Redirect has priority over everything. At the edge where redirect_valid=1:
  - buffer flushed (count=0, out_valid=0 next cycle);
  - pc <= redirect_pc;
  - no enq;
  - a deq presented in the same cycle still counts as consumed by decode, but the entry is discarded.
  - The first redirected instruction appears at out_* 2 cycles after the redirect edge: the fetch edge, then the output cycle.
- Buffer is a 2-entry FIFO with count 0..2; the head drives out_*:
  - count=2 & ~deq: no enq, pc holds (back-pressure).
  - count=2 & deq: pop and push on the same edge, count stays 2.
  - count=0: out_valid=0; out_instr/out_pc hold their last values (don't-care).
- out_instr/out_pc stay stable while out_valid=1 & ~out_ready.
- fetch_en=0: buffer keeps draining, pc frozen.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t struct {pc[ADDR_W], instr[DATA_W]};
  - RESET_PC_DEFAULT constant;
  - PC_STEP_DEFAULT constant.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head outputs, and the same clk/rst_n.
- The PC register and enq/redirect logic stay in instruction_fetch.

Test Plan:
- Sequential fetch. Bench memory mem[i]=32'hA000_0000+i, out_ready=1, fetch_en=1, release reset. Required: cycle 1 out (pc=0, instr=A0000000); cycle 2 (1, A0000001); then one per cycle; imem_addr=0,1,2,… .
- Back-pressure. out_ready=0 from reset. Required: after 2 fetches count=2, pc=2 and holds; out stays (0, A0000000). Raise out_ready: outputs pc 0,1,2,3 on consecutive cycles with no gap or duplicate.
- Full with simultaneous pop and push. count=2, out_ready=1 for one cycle. Required: count stays 2, head advances 0→1, pc 2→3.
- Redirect flush. At pc=5 with 2 entries buffered, redirect_valid=1, redirect_pc=0x40 for one cycle. Required: out_valid=0 next cycle; the cycle after shows (0x40, mem[0x40]); no entry with pc 3..5 emerges afterwards.
- fetch_en gating and wrap. fetch_en=0 for 3 cycles: pc frozen, buffer drains, out_valid=0. redirect_pc=32'hFFFF_FFFF then fetch 2: out_pc FFFFFFFF then 0.
- Reset mid-operation. Assert rst_n=0 asynchronously between edges while count=2. Required: out_valid=0 and imem_addr=0 immediately; after release, fetch restarts at pc 0.
